// File: rtl/i2c_cmd_sequencer.sv
// Command FIFO in front of an I2C master: launches queued transactions one at a
// time and detects completion by passively watching START/STOP on SCL/SDA.
module i2c_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int GAP_CYCLES     = 100
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [6:0]                  cmd_addr,
    input  logic [7:0]                  cmd_reg,
    input  logic [7:0]                  cmd_data,
    input  logic                        cmd_rw,
    input  logic                        SCL,
    input  logic                        SDA,
    output logic [6:0]                  m_addr,
    output logic [7:0]                  m_reg_addr,
    output logic [7:0]                  m_data,
    output logic                        m_rw,
    output logic                        m_start_tx,
    input  logic [7:0]                  m_data_o,
    output logic                        rd_valid,
    output logic [7:0]                  rd_data,
    output logic                        err_timeout,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] reg_addr;
        logic [7:0] data;
        logic       rw;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, LAUNCH, XFER, GAP} state_t;

    cmd_t          mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    state_t        state_q, state_d;
    cmd_t          m_cmd_q, m_cmd_d;
    logic          m_start_tx_q, m_start_tx_d;
    logic          rd_valid_q, rd_valid_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [GW-1:0] gap_q, gap_d;

    logic scl_s1_q, scl_s2_q, scl_prev_q;
    logic sda_s1_q, sda_s2_q, sda_prev_q;
    logic start_det, stop_det, tmo_expire;

    assign cmd_ready = (count_q != CW'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;

    // NOTE: the storage array has no reset; emptiness is defined by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_addr, cmd_reg, cmd_data, cmd_rw};
        end
    end

    // Synchronizers idle high so reset never looks like a bus edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {scl_s1_q, scl_s2_q, scl_prev_q} <= 3'b111;
            {sda_s1_q, sda_s2_q, sda_prev_q} <= 3'b111;
        end else begin
            scl_s1_q   <= SCL;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= SDA;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
        end
    end

    assign start_det  = scl_s2_q && scl_prev_q && sda_prev_q && !sda_s2_q;
    assign stop_det   = scl_s2_q && scl_prev_q && !sda_prev_q && sda_s2_q;
    assign tmo_expire = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        m_cmd_d      = m_cmd_q;
        m_start_tx_d = m_start_tx_q;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        err_d        = 1'b0;
        tmo_d        = tmo_q;
        gap_d        = gap_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: pop = (count_q != '0);
            LAUNCH: begin
                tmo_d = tmo_q + TW'(1);
                if (tmo_expire) begin
                    err_d        = 1'b1;
                    m_start_tx_d = 1'b0;
                    gap_d        = '0;
                    state_d      = GAP;
                end else if (start_det) begin
                    m_start_tx_d = 1'b0;
                    state_d      = XFER;
                end
            end
            XFER: begin
                tmo_d = tmo_q + TW'(1);
                if (stop_det) begin
                    if (m_cmd_q.rw) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = m_data_o;
                    end
                    gap_d   = '0;
                    state_d = GAP;
                end else if (tmo_expire) begin
                    err_d   = 1'b1;
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                // A queued command launches straight out of the gap, skipping IDLE.
                if (gap_q == GW'(GAP_CYCLES)) begin
                    pop     = (count_q != '0);
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            m_cmd_d      = mem_q[rd_ptr_q];
            m_start_tx_d = 1'b1;
            tmo_d        = '0;
            state_d      = LAUNCH;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            m_cmd_q      <= '0;
            m_start_tx_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
            gap_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            m_cmd_q      <= m_cmd_d;
            m_start_tx_q <= m_start_tx_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    assign m_addr      = m_cmd_q.addr;
    assign m_reg_addr  = m_cmd_q.reg_addr;
    assign m_data      = m_cmd_q.data;
    assign m_rw        = m_cmd_q.rw;
    assign m_start_tx  = m_start_tx_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != IDLE) || (count_q != '0);
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer: bus-level slave model plus a
// scoreboard of expected launches and read results.
module tb_i2c_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 1000;
    localparam int GAP   = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_reg = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_rw = 1'b0;
    logic       SCL = 1'b1;
    logic       SDA = 1'b1;
    logic [6:0] m_addr;
    logic [7:0] m_reg_addr;
    logic [7:0] m_data;
    logic       m_rw;
    logic       m_start_tx;
    logic [7:0] m_data_o;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       err_timeout;
    logic       busy;
    logic [2:0] fifo_count;

    logic [7:0]  slave_mem [256];
    logic [23:0] exp_cmd [$];
    logic [7:0]  exp_rd [$];
    int checks = 0;
    int errors = 0;
    int rd_cycles = 0;
    int err_cycles = 0;
    int cyc = 0;
    int launch_cyc = 0;
    logic start_prev = 1'b0;

    i2c_cmd_sequencer #(
        .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_reg(cmd_reg), .cmd_data(cmd_data), .cmd_rw(cmd_rw),
        .SCL(SCL), .SDA(SDA), .m_addr(m_addr), .m_reg_addr(m_reg_addr),
        .m_data(m_data), .m_rw(m_rw), .m_start_tx(m_start_tx), .m_data_o(m_data_o),
        .rd_valid(rd_valid), .rd_data(rd_data), .err_timeout(err_timeout),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model answers reads from its register file.
    assign m_data_o = slave_mem[m_reg_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (m_start_tx && !start_prev) begin
                if (exp_cmd.size() == 0) check("launch_unexp", 32'(m_start_tx), 32'd0);
                else check("launch_cmd", 32'({m_addr, m_reg_addr, m_data, m_rw}),
                           32'(exp_cmd.pop_front()));
            end
            if (rd_valid) begin
                rd_cycles++;
                if (exp_rd.size() == 0) check("rd_unexp", 32'(rd_valid), 32'd0);
                else check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
            end
            if (err_timeout) err_cycles++;
        end
        start_prev = m_start_tx;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_cmd(input logic [6:0] a, input logic [7:0] r,
                            input logic [7:0] d, input logic rw);
        int n = 0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_reg = r; cmd_data = d; cmd_rw = rw;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("push_wait", 32'(cmd_ready), 32'd1);
        end else begin
            @(negedge clk);
            exp_cmd.push_back({a, r, d, rw});
            if (rw) exp_rd.push_back(slave_mem[r]);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_launch();
        int n = 0;
        while (!m_start_tx && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!m_start_tx) check("launch_wait", 32'(m_start_tx), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic bus_start();
        SDA = 1'b0; wait_n(4);
        SCL = 1'b0; wait_n(4);
    endtask

    task automatic bus_stop();
        SDA = 1'b0; wait_n(4);
        SCL = 1'b1; wait_n(4);
        if (!m_rw) slave_mem[m_reg_addr] = m_data;
        SDA = 1'b1;
    endtask

    task automatic do_xfer();
        wait_launch();
        wait_n(2);
        bus_start();
        bus_stop();
        wait_n(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) slave_mem[i] = 8'h00;
        slave_mem[8'h05] = 8'h5A;
        slave_mem[8'h07] = 8'h3C;

        // Asynchronous reset, before any clock edge.
        #1 rst = 1'b0;
        #2;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(m_start_tx), 32'd0);
        check("rst_m", 32'({m_addr, m_reg_addr, m_data, m_rw}), 32'd0);
        check("rst_pulses", 32'({rd_valid, err_timeout}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_n(2);

        // Write: launch timing, START handling, gap length.
        push_cmd(7'h11, 8'h00, 8'hAA, 1'b0);
        check("wr_count_after_push", 32'(fifo_count), 32'd1);
        check("wr_start_edge1", 32'(m_start_tx), 32'd0);
        wait_n(1);
        check("wr_start_edge2", 32'(m_start_tx), 32'd1);
        check("wr_count_popped", 32'(fifo_count), 32'd0);
        wait_n(2);
        SDA = 1'b0;
        wait_n(2);
        check("wr_start_held", 32'(m_start_tx), 32'd1);
        wait_n(1);
        check("wr_start_fall", 32'(m_start_tx), 32'd0);
        wait_n(1);
        SCL = 1'b0;
        wait_n(2);
        bus_stop();
        wait_n(3 + GAP);
        check("wr_busy_gap", 32'(busy), 32'd1);
        wait_n(1);
        check("wr_busy_fall", 32'(busy), 32'd0);
        check("wr_slave_reg", 32'(slave_mem[8'h00]), 32'hAA);
        check("wr_no_rd", 32'(rd_cycles), 32'd0);

        // Read.
        push_cmd(7'h11, 8'h05, 8'h00, 1'b1);
        do_xfer();
        wait_idle();
        wait_n(2);
        check("rd_pulses", 32'(rd_cycles), 32'd1);
        check("rd_hold", 32'(rd_data), 32'h5A);

        // Full FIFO with idle bus; the first command then times out.
        push_cmd(7'h12, 8'h30, 8'hEE, 1'b0);
        push_cmd(7'h12, 8'h20, 8'h01, 1'b0);
        check("full_launch", 32'(m_start_tx), 32'd1);
        launch_cyc = cyc;
        push_cmd(7'h12, 8'h07, 8'h00, 1'b1);
        push_cmd(7'h12, 8'h21, 8'h02, 1'b0);
        push_cmd(7'h12, 8'h22, 8'h03, 1'b0);
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1; cmd_addr = 7'h12; cmd_reg = 8'h23; cmd_data = 8'h04; cmd_rw = 1'b0;
        wait_n(5);
        check("full_hold", 32'(fifo_count), 32'd4);
        while (cyc < launch_cyc + TMO - 1) wait_n(1);
        check("tmo_early", 32'(err_timeout), 32'd0);
        check("tmo_start_high", 32'(m_start_tx), 32'd1);
        wait_n(1);
        check("tmo_fire", 32'(err_timeout), 32'd1);
        check("tmo_start_drop", 32'(m_start_tx), 32'd0);
        wait_n(1);
        check("tmo_one_cycle", 32'(err_timeout), 32'd0);
        wait_n(GAP - 1);
        check("tmo_gap_start", 32'(m_start_tx), 32'd0);
        check("tmo_gap_count", 32'(fifo_count), 32'd4);
        wait_n(1);
        check("tmo_next_launch", 32'(m_start_tx), 32'd1);
        check("tmo_next_count", 32'(fifo_count), 32'd3);
        check("tmo_ready", 32'(cmd_ready), 32'd1);
        push_cmd(7'h12, 8'h23, 8'h04, 1'b0);
        check("full_refill", 32'(fifo_count), 32'd4);
        for (int i = 0; i < 5; i++) do_xfer();
        wait_idle();
        wait_n(2);
        check("full_wr_first", 32'(slave_mem[8'h20]), 32'h01);
        check("full_wr_last", 32'(slave_mem[8'h23]), 32'h04);
        check("full_discarded", 32'(slave_mem[8'h30]), 32'h00);
        check("full_rd_hold", 32'(rd_data), 32'h3C);

        // Glitches: STOP in IDLE and LAUNCH, repeated START in XFER.
        SDA = 1'b0; wait_n(4);
        SDA = 1'b1; wait_n(5);
        check("gl_idle_busy", 32'(busy), 32'd0);
        check("gl_idle_start", 32'(m_start_tx), 32'd0);
        push_cmd(7'h22, 8'h10, 8'h77, 1'b0);
        wait_launch();
        SCL = 1'b0; wait_n(2);
        SDA = 1'b0; wait_n(2);
        SCL = 1'b1; wait_n(2);
        SDA = 1'b1; wait_n(5);
        check("gl_launch_stop", 32'(m_start_tx), 32'd1);
        bus_start();
        check("gl_xfer", 32'(m_start_tx), 32'd0);
        SDA = 1'b1; wait_n(2);
        SCL = 1'b1; wait_n(2);
        SDA = 1'b0; wait_n(4);
        SCL = 1'b0; wait_n(2);
        check("gl_rep_start", 32'(busy), 32'd1);
        bus_stop();
        wait_n(3 + GAP);
        check("gl_busy_gap", 32'(busy), 32'd1);
        wait_n(1);
        check("gl_busy_fall", 32'(busy), 32'd0);
        check("gl_slave_reg", 32'(slave_mem[8'h10]), 32'h77);

        // Reset in the middle of a transfer with a command still queued.
        push_cmd(7'h33, 8'h40, 8'h99, 1'b0);
        wait_launch();
        wait_n(2);
        SDA = 1'b0; wait_n(4);
        SCL = 1'b0;
        push_cmd(7'h34, 8'h41, 8'h98, 1'b1);
        check("mid_queued", 32'(fifo_count), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_m", 32'({m_addr, m_reg_addr, m_data, m_rw}), 32'd0);
        check("mid_rst_start", 32'(m_start_tx), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rd", 32'({rd_valid, rd_data, err_timeout}), 32'd0);
        exp_cmd.delete();
        exp_rd.delete();
        SCL = 1'b1;
        SDA = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        wait_n(20);
        check("post_rst_start", 32'(m_start_tx), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        push_cmd(7'h35, 8'h42, 8'h11, 1'b0);
        do_xfer();
        wait_idle();
        wait_n(2);
        check("post_rst_xfer", 32'(slave_mem[8'h42]), 32'h11);

        check("end_rd_pulses", 32'(rd_cycles), 32'd2);
        check("end_err_pulses", 32'(err_cycles), 32'd1);
        check("end_cmd_queue", 32'(exp_cmd.size()), 32'd0);
        check("end_rd_queue", 32'(exp_rd.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
